// File: rtl/color_stream_pkg.sv
// Shared types and defaults for the color-ID video path.
// Holds the color-ID type, the Avalon-ST beat layout used by the read-ahead
// FIFO, the frame-reader FSM state encoding and the default frame geometry
// shared with the color mapper and video timing blocks.
package color_stream_pkg;

   localparam int unsigned DefaultHRes = 640;
   localparam int unsigned DefaultVRes = 480;

   typedef logic [15:0] color_id_t;

   // One stream beat with its packet flags.
   typedef struct packed {
      logic      eop;
      logic      sop;
      color_id_t data;
   } stream_beat_t;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDrain
   } src_state_e;

endpackage

// File: rtl/color_id_skid_fifo.sv
// Two-entry FIFO of stream beats used as the read-ahead buffer.
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-high reset, clears contents and pointers
//   i_push       write i_push_beat this cycle
//   i_push_beat  beat to write
//   i_pop        remove the head entry this cycle
//   o_count      number of stored entries (0..2)
//   o_head       oldest entry; all zeros after reset
// Push and pop may occur in the same cycle.
module color_id_skid_fifo
   import color_stream_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_push,
   input  stream_beat_t i_push_beat,
   input  logic         i_pop,
   output logic [1:0]   o_count,
   output stream_beat_t o_head
);

   stream_beat_t r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;

   logic w_pop;
   logic w_push;

   // Guard against misuse: no pop when empty, no push when full unless a
   // pop frees the slot in the same cycle.
   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_beat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/color_id_stream_source.sv
// Frame-buffer reader producing the Avalon-ST color-ID stream.
// On FRAME_START (while idle) it reads H_RES*V_RES 16-bit IDs from a
// synchronous RAM starting at base 0 or H_RES*V_RES (BUFFER_SEL) and emits
// them one per beat with sop on the first and eop on the last pixel.
// Ports:
//   CLK_clk                        clock
//   RESET_reset                    synchronous active-high reset
//   FRAME_START / BUFFER_SEL       frame request and buffer select
//   BUSY / FRAME_DONE              frame in progress / last beat accepted pulse
//   FB_ADDR / FB_READ / FB_READDATA  RAM read port, data one cycle after read
//   COLOR_ID_SOURCE_*              Avalon-ST source, readyLatency 0
module color_id_stream_source
   import color_stream_pkg::*;
#(
   parameter int unsigned H_RES  = DefaultHRes,
   parameter int unsigned V_RES  = DefaultVRes,
   parameter int unsigned ADDR_W = 20
) (
   input  logic              CLK_clk,
   input  logic              RESET_reset,
   input  logic              FRAME_START,
   input  logic              BUFFER_SEL,
   output logic              BUSY,
   output logic              FRAME_DONE,
   output logic [ADDR_W-1:0] FB_ADDR,
   output logic              FB_READ,
   input  logic [15:0]       FB_READDATA,
   output logic [15:0]       COLOR_ID_SOURCE_data,
   output logic              COLOR_ID_SOURCE_startofpacket,
   output logic              COLOR_ID_SOURCE_endofpacket,
   output logic              COLOR_ID_SOURCE_valid,
   input  logic              COLOR_ID_SOURCE_ready
);

   localparam int unsigned NumPix = H_RES * V_RES;
   localparam int unsigned CntW   = $clog2(NumPix + 1);
   localparam logic [CntW-1:0] LastIdx = CntW'(NumPix - 1);

   src_state_e        r_state;
   src_state_e        w_state_next;
   logic [ADDR_W-1:0] r_base;
   logic [CntW-1:0]   r_issue_cnt;
   logic              r_inflight;
   logic              r_inflight_sop;
   logic              r_inflight_eop;
   logic              r_frame_done;

   logic              w_busy;
   logic              w_fb_read;
   logic              w_pop;
   logic              w_valid;
   logic [1:0]        w_fifo_count;
   logic [2:0]        w_credit_used;
   stream_beat_t      w_head;
   stream_beat_t      w_push_beat;

   assign w_valid = (w_fifo_count != 2'd0);
   assign w_pop   = w_valid && COLOR_ID_SOURCE_ready;

   // Entries that will occupy the FIFO after this cycle if no new read is
   // issued; a read is allowed only while that leaves room for its data.
   assign w_credit_used = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   // State register
   always_ff @(posedge CLK_clk) begin
      if (RESET_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (FRAME_START) begin
               w_state_next = StStream;
            end
         end
         StStream: begin
            if (w_fb_read && (r_issue_cnt == LastIdx)) begin
               w_state_next = StDrain;
            end
         end
         StDrain: begin
            if (w_pop && w_head.eop) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_busy    = 1'b0;
      w_fb_read = 1'b0;
      unique case (r_state)
         StIdle:   w_busy = 1'b0;
         StStream: begin
            w_busy    = 1'b1;
            w_fb_read = (w_credit_used < 3'd2);
         end
         StDrain:  w_busy = 1'b1;
         default:  w_busy = 1'b0;
      endcase
   end

   // Issue counter, base latch and in-flight read tracking. Flags travel
   // with the read so the FIFO entry is complete when the data lands.
   always_ff @(posedge CLK_clk) begin
      if (RESET_reset) begin
         r_base         <= '0;
         r_issue_cnt    <= '0;
         r_inflight     <= 1'b0;
         r_inflight_sop <= 1'b0;
         r_inflight_eop <= 1'b0;
         r_frame_done   <= 1'b0;
      end else begin
         if ((r_state == StIdle) && FRAME_START) begin
            r_base      <= BUFFER_SEL ? ADDR_W'(NumPix) : '0;
            r_issue_cnt <= '0;
         end else if (w_fb_read) begin
            r_issue_cnt <= r_issue_cnt + CntW'(1);
         end
         r_inflight     <= w_fb_read;
         r_inflight_sop <= (r_issue_cnt == '0);
         r_inflight_eop <= (r_issue_cnt == LastIdx);
         r_frame_done   <= (r_state == StDrain) && w_pop && w_head.eop;
      end
   end

   assign w_push_beat = '{eop: r_inflight_eop, sop: r_inflight_sop, data: FB_READDATA};

   color_id_skid_fifo u_fifo (
      .i_clk       (CLK_clk),
      .i_reset     (RESET_reset),
      .i_push      (r_inflight),
      .i_push_beat (w_push_beat),
      .i_pop       (w_pop),
      .o_count     (w_fifo_count),
      .o_head      (w_head)
   );

   assign BUSY       = w_busy;
   assign FRAME_DONE = r_frame_done;
   assign FB_READ    = w_fb_read;
   assign FB_ADDR    = r_base + ADDR_W'(r_issue_cnt);

   assign COLOR_ID_SOURCE_data          = w_head.data;
   assign COLOR_ID_SOURCE_startofpacket = w_head.sop;
   assign COLOR_ID_SOURCE_endofpacket   = w_head.eop;
   assign COLOR_ID_SOURCE_valid         = w_valid;

endmodule
